// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: folds E0/F0/E1 prefix sequences into single key
// events, tracks live shift state and queues events in a show-ahead FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       ev_valid,
  input  logic       ev_ack,
  output logic       shift,
  output logic       overflow
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_E0    = 3'd1,
    ST_F0    = 3'd2,
    ST_E0F0  = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = FIFO_DEPTH[ADDR_W:0];

  // Event handshake: the head entry is presented while ev_valid is high and is
  // removed on any clock edge where ev_valid & ev_ack; ev_ack is ignored when empty.

  state_t            state;
  state_t            state_nx;
  logic [2:0]        skip_cnt;
  logic [2:0]        skip_nx;
  logic              rdy_q;
  logic              new_byte;
  logic              emit;
  logic [9:0]        emit_entry;
  logic              is_kill;
  logic              is_noise;
  logic              lsh;
  logic              rsh;
  logic [9:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              pop;
  logic              do_push;

  assign new_byte = rx_rdy & ~rdy_q;
  assign is_kill  = (rx_data == 8'h00) || (rx_data == 8'hFF);
  assign is_noise = is_kill || (rx_data == 8'hAA) || (rx_data == 8'hFA) ||
                    (rx_data == 8'hFE) || (rx_data == 8'hEE);

  always_comb begin
    state_nx   = state;
    skip_nx    = skip_cnt;
    emit       = 1'b0;
    emit_entry = {2'b00, rx_data};
    if (new_byte) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == 8'hE0) begin
            state_nx = ST_E0;
          end else if (rx_data == 8'hF0) begin
            state_nx = ST_F0;
          end else if (rx_data == 8'hE1) begin
            state_nx = ST_PAUSE;
            skip_nx  = 3'd7;
          end else if (!is_noise) begin
            emit = 1'b1;
          end
        end
        ST_E0: begin
          if (rx_data == 8'hF0) begin
            state_nx = ST_E0F0;
          end else if (rx_data == 8'hE0) begin
            state_nx = ST_E0;
          end else if (is_kill) begin
            state_nx = ST_IDLE;
          end else begin
            emit       = 1'b1;
            emit_entry = {2'b10, rx_data};
            state_nx   = ST_IDLE;
          end
        end
        ST_F0: begin
          state_nx = ST_IDLE;
          if (!is_kill) begin
            emit       = 1'b1;
            emit_entry = {2'b01, rx_data};
          end
        end
        ST_E0F0: begin
          state_nx = ST_IDLE;
          if (!is_kill) begin
            emit       = 1'b1;
            emit_entry = {2'b11, rx_data};
          end
        end
        ST_PAUSE: begin
          // The Pause key sends 7 bytes after E1 with no break; report it once.
          if (skip_cnt <= 3'd1) begin
            emit       = 1'b1;
            emit_entry = {2'b10, 8'hE1};
            state_nx   = ST_IDLE;
            skip_nx    = 3'd0;
          end else begin
            skip_nx = skip_cnt - 3'd1;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          skip_nx  = 3'd0;
        end
      endcase
    end
  end

  assign full    = (count == DEPTH_L);
  assign pop     = ev_valid & ev_ack;
  assign do_push = emit & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      // rdy_q starts high so a level already asserted is not seen as a byte.
      rdy_q    <= 1'b1;
      state    <= ST_IDLE;
      skip_cnt <= 3'd0;
      lsh      <= 1'b0;
      rsh      <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 10'h000;
      end
    end else begin
      rdy_q    <= rx_rdy;
      state    <= state_nx;
      skip_cnt <= skip_nx;

      // Shift state follows the keyboard even when the event itself is dropped.
      if (emit && !emit_entry[9]) begin
        if (emit_entry[7:0] == 8'h12) lsh <= ~emit_entry[8];
        if (emit_entry[7:0] == 8'h59) rsh <= ~emit_entry[8];
      end

      if (emit && full && !pop) begin
        overflow <= 1'b1;
      end
      if (do_push) begin
        mem[wr_ptr] <= emit_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign ev_valid = (count != '0);
  assign ev_code  = mem[rd_ptr][7:0];
  assign ev_brk   = mem[rd_ptr][8];
  assign ev_ext   = mem[rd_ptr][9];
  assign shift    = lsh | rsh;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed vector table, hand sequences for
// multi-cycle cases, and random bytes checked against a prefix/queue model.
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic       ev_valid;
  logic       ev_ack;
  logic       shift;
  logic       overflow;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_brk(ev_brk), .ev_valid(ev_valid),
    .ev_ack(ev_ack), .shift(shift), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: expected events {ext, brk, code}, oldest first.
  logic [9:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Model: pending prefix flags and bytes left to skip for Pause.
  bit m_ext, m_brk, m_prev_rdy, m_lsh, m_rsh, m_ovf;
  int m_skip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output bit emit, output logic [9:0] ev);
    emit = 0;
    ev   = 10'h000;
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) begin
        emit = 1;
        ev   = {2'b10, 8'hE1};
      end
    end else if (b == 8'h00 || b == 8'hFF) begin
      m_ext = 0;
      m_brk = 0;
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_skip = 7;
      else if (!(b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE)) begin
        emit = 1;
        ev   = {2'b00, b};
      end
    end else if (m_brk) begin
      emit  = 1;
      ev    = {m_ext, 1'b1, b};
      m_ext = 0;
      m_brk = 0;
    end else begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        emit  = 1;
        ev    = {2'b10, b};
        m_ext = 0;
      end
    end
    if (emit && !ev[9]) begin
      if (ev[7:0] == 8'h12) m_lsh = !ev[8];
      if (ev[7:0] == 8'h59) m_rsh = !ev[8];
    end
  endtask

  task automatic model_edge(input logic r, input logic rdy, input logic [7:0] d, input logic a);
    bit emit;
    bit pop;
    logic [9:0] ev;
    if (r) begin
      exp_q.delete();
      m_ext = 0; m_brk = 0; m_skip = 0;
      m_lsh = 0; m_rsh = 0; m_ovf = 0;
      m_prev_rdy = 1;
    end else begin
      pop  = a && (exp_q.size() > 0);
      emit = 0;
      ev   = 10'h000;
      if (rdy && !m_prev_rdy) model_byte(d, emit, ev);
      m_prev_rdy = rdy;
      if (pop) void'(exp_q.pop_front());
      if (emit) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(ev);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("valid", ev_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check("head", {ev_ext, ev_brk, ev_code}, exp_q[0]);
    check("shift", shift, m_lsh | m_rsh);
    check("overflow", overflow, m_ovf);
  endtask

  // One clock: inputs change at the falling edge, outputs sampled at the next one.
  task automatic cycle(input logic r, input logic rdy, input logic [7:0] d, input logic a);
    rst = r; rx_rdy = rdy; rx_data = d; ev_ack = a;
    @(posedge clk);
    model_edge(r, rdy, d, a);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b0, 1'b1, b, 1'b0);
    cycle(1'b0, 1'b0, b, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int g = 0; g < 16 && ev_valid; g++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      n++;
    end
  endtask

  typedef struct {
    logic [7:0] b [3];
    int         n;
    logic       exp_valid;
    logic [9:0] exp_ev;
  } vec_t;

  vec_t vecs[12];

  task automatic set_vec(input int i, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int n, input logic v, input logic [9:0] e);
    vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2;
    vecs[i].n = n; vecs[i].exp_valid = v; vecs[i].exp_ev = e;
  endtask

  initial begin
    int n;
    logic [7:0] pool [8];
    logic [7:0] d;
    logic r;

    set_vec(0,  8'h1C, 8'h00, 8'h00, 1, 1'b1, 10'h01C);
    set_vec(1,  8'hF0, 8'h1C, 8'h00, 2, 1'b1, 10'h11C);
    set_vec(2,  8'hE0, 8'h75, 8'h00, 2, 1'b1, 10'h275);
    set_vec(3,  8'hE0, 8'hF0, 8'h75, 3, 1'b1, 10'h375);
    set_vec(4,  8'hAA, 8'h00, 8'h00, 1, 1'b0, 10'h000);
    set_vec(5,  8'hE0, 8'h00, 8'h00, 2, 1'b0, 10'h000);
    set_vec(6,  8'hF0, 8'hFF, 8'h00, 2, 1'b0, 10'h000);
    set_vec(7,  8'hE0, 8'hE0, 8'h75, 3, 1'b1, 10'h275);
    set_vec(8,  8'hFA, 8'h00, 8'h00, 1, 1'b0, 10'h000);
    set_vec(9,  8'hE0, 8'hF0, 8'hFF, 3, 1'b0, 10'h000);
    set_vec(10, 8'h59, 8'h00, 8'h00, 1, 1'b1, 10'h059);
    set_vec(11, 8'hF0, 8'hE0, 8'h00, 2, 1'b1, 10'h1E0);

    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; ev_ack = 1'b0;
    do_reset();
    check("rst_valid", ev_valid, 1'b0);
    check("rst_code", ev_code, 8'h00);
    check("rst_ext", ev_ext, 1'b0);
    check("rst_brk", ev_brk, 1'b0);
    check("rst_shift", shift, 1'b0);
    check("rst_overflow", overflow, 1'b0);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      for (int j = 0; j < vecs[i].n; j++) send(vecs[i].b[j]);
      check("vec_valid", ev_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check("vec_event", {ev_ext, ev_brk, ev_code}, vecs[i].exp_ev);
    end

    // Latency: event visible right after the edge that samples the rising rdy.
    do_reset();
    check("lat_before", ev_valid, 1'b0);
    cycle(1'b0, 1'b1, 8'h1C, 1'b0);
    check("lat_after", ev_valid, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    send(8'hF0); send(8'h1C);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("lat_second", {ev_ext, ev_brk, ev_code}, 10'h11C);

    // Shift tracking with a fake (extended) shift in between.
    do_reset();
    send(8'h12);
    check("shift_make", shift, 1'b1);
    send(8'hE0); send(8'h12);
    check("shift_fake", shift, 1'b1);
    send(8'hF0); send(8'h12);
    check("shift_break", shift, 1'b0);
    drain(n);
    check("shift_events", n, 3);

    // Pause sequence yields one event, then normal decoding resumes.
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_event", {ev_ext, ev_brk, ev_code}, 10'h2E1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("pause_single", ev_valid, 1'b0);
    send(8'h1C);
    check("pause_after", {ev_valid, ev_ext, ev_brk, ev_code}, 11'h41C);

    // Overflow, then push and pop together on a full queue.
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", {ev_ext, ev_brk, ev_code}, 10'h016);
    cycle(1'b0, 1'b1, 8'h36, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("ovf_pushpop_head", {ev_ext, ev_brk, ev_code}, 10'h01E);
    check("ovf_sticky", overflow, 1'b1);

    // Reset mid-prefix with events queued, then a fresh byte.
    send(8'hE0); send(8'hF0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("mid_rst_valid", ev_valid, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    send(8'h75);
    check("mid_rst_event", {ev_ext, ev_brk, ev_code}, 10'h075);

    // Level held high counts once; AA is noise.
    do_reset();
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 8'h1C, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    drain(n);
    check("level_once", n, 1);
    send(8'hAA);
    check("aa_ignored", ev_valid, 1'b0);

    // Random bytes, levels and acks against the model.
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'hE1; pool[3] = 8'h12;
    pool[4] = 8'h59; pool[5] = 8'h00; pool[6] = 8'hAA; pool[7] = 8'hFF;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 0) d = pool[$urandom_range(0, 7)];
      else d = 8'($urandom_range(0, 255));
      cycle(r, 1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
